flag_update_sequencer: RTL

//  Upstream driver for the L/C/X flag flip-flops. Accepts a per-flag update command

---
 rtl/flag_update_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/flag_update_sequencer.sv
// Flag update sequencer: runs per-flag update commands through P1 (ALU capture),
// P2 (set/reset issue) and P3 (done), with a one-deep pending command buffer.
module flag_update_sequencer #(
  parameter int unsigned NUM_FLAGS = 3,
  parameter int unsigned P2_CYCLES = 1
) (
  input  logic                   Clk,
  input  logic                   notClk,
  input  logic                   notReset,
  input  logic                   Start,
  input  logic [2*NUM_FLAGS-1:0] FlagOp,
  input  logic [NUM_FLAGS-1:0]   AluFlags,
  output logic [NUM_FLAGS-1:0]   P2_Set,
  output logic [NUM_FLAGS-1:0]   P2_Reset,
  output logic [1:0]             Phase,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Overrun
);

  localparam int unsigned   CW       = (P2_CYCLES > 1) ? $clog2(P2_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(P2_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P1   = 2'd1,
    S_P2   = 2'd2,
    S_P3   = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [2*NUM_FLAGS-1:0] r_op, w_op_nxt;
  logic [2*NUM_FLAGS-1:0] r_pend_op, w_pend_op_nxt;
  logic                   r_pend, w_pend_nxt;
  logic [NUM_FLAGS-1:0]   r_alu, w_alu_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   r_ovr, w_ovr_nxt;

  // notClk is only forwarded to the flag flip-flops; not used here
  logic w_unused;
  assign w_unused = notClk;

  // State and datapath registers
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_pend_op <= '0;
      r_pend    <= 1'b0;
      r_alu     <= '0;
      r_cnt     <= '0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_pend_op <= w_pend_op_nxt;
      r_pend    <= w_pend_nxt;
      r_alu     <= w_alu_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ovr     <= w_ovr_nxt;
    end
  end

  // Next-state, command buffering and overrun detection
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_pend_op_nxt = r_pend_op;
    w_pend_nxt    = r_pend;
    w_alu_nxt     = r_alu;
    w_cnt_nxt     = r_cnt;
    w_ovr_nxt     = r_ovr;

    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_op_nxt    = FlagOp;
          w_state_nxt = S_P1;
        end
      end
      S_P1: begin
        w_alu_nxt   = AluFlags;
        w_cnt_nxt   = CNT_LOAD;
        w_state_nxt = S_P2;
      end
      S_P2: begin
        if (r_cnt == '0) w_state_nxt = S_P3;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_P3: begin
        if (r_pend) begin
          w_op_nxt    = r_pend_op;
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_P1;
        end else if (Start) begin
          // Buffer-then-promote collapsed: the new command goes straight to active
          w_op_nxt    = FlagOp;
          w_state_nxt = S_P1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (Start && (r_state != S_IDLE)) begin
      if (r_pend) begin
        w_ovr_nxt = 1'b1;
      end else if (r_state != S_P3) begin
        w_pend_op_nxt = FlagOp;
        w_pend_nxt    = 1'b1;
      end
    end
  end

  // Set/reset decode from registered op and ALU flags, active only in P2
  always_comb begin
    P2_Set   = '0;
    P2_Reset = '0;
    if (r_state == S_P2) begin
      for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
        case (r_op[2*i +: 2])
          2'b01:   P2_Set[i]   = 1'b1;
          2'b10:   P2_Reset[i] = 1'b1;
          2'b11: begin
            P2_Set[i]   = r_alu[i];
            P2_Reset[i] = ~r_alu[i];
          end
          default: ;
        endcase
      end
    end
  end

  assign Phase   = r_state;
  assign Busy    = (r_state != S_IDLE);
  assign Done    = (r_state == S_P3);
  assign Overrun = r_ovr;

endmodule
